// File: rtl/unpoolchan2_pkg.sv
// Shared definitions for the layer-2 unpool channel: pooled/feature-map geometry,
// map typedefs common with the pool channel, row-index width and FSM state codes.
package unpoolchan2_pkg;

    localparam int POOL2_H   = 4;
    localparam int POOL2_W   = 4;
    localparam int FMAP2_H   = 2 * POOL2_H;
    localparam int FMAP2_W   = 2 * POOL2_W;
    localparam int ROW_IDX_W = $clog2(FMAP2_H);

    // Row-major, MSB-first maps: element 0 is cell (0,0).
    typedef logic [0:POOL2_H*POOL2_W-1]   d_pool2_t;
    typedef logic [0:FMAP2_H*FMAP2_W-1]   d_fmap2_t;
    typedef logic [0:2*POOL2_H*POOL2_W-1] d_sel2_t;
    typedef logic [0:FMAP2_W-1]           d_row2_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;

endpackage

// File: rtl/unpool_row_expand.sv
// Combinational expansion of one pooled row into one output row.
// UNPOOL_SWITCH_EN selects max-unpool placement; otherwise 2x nearest-neighbour.
module unpool_row_expand
    import unpoolchan2_pkg::*;
#(
    parameter int POOL_W = POOL2_W
) (
    input  logic [0:POOL_W-1]   pool_row,
`ifdef UNPOOL_SWITCH_EN
    input  logic [0:2*POOL_W-1] sel_row,
    input  logic                parity,
`endif
    output logic [0:2*POOL_W-1] out_row
);

    always_comb begin
        out_row = '0;
        for (int c = 0; c < POOL_W; c++) begin
`ifdef UNPOOL_SWITCH_EN
            // sel_row pair per cell is {dy,dx}; the bit lands only on its argmax slot.
            out_row[2*c]   = pool_row[c] & (sel_row[2*c] == parity) & ~sel_row[2*c+1];
            out_row[2*c+1] = pool_row[c] & (sel_row[2*c] == parity) &  sel_row[2*c+1];
`else
            out_row[2*c]   = pool_row[c];
            out_row[2*c+1] = pool_row[c];
`endif
        end
    end

endmodule

// File: rtl/unpoolchan2.sv
// Layer-2 unpool channel: accepts a pooled binary map, streams the 2x upsampled map
// one registered row per beat. Define UNPOOL_SWITCH_EN for argmax-select max-unpool.
module unpoolchan2
    import unpoolchan2_pkg::*;
#(
    parameter int  POOL_H = POOL2_H,
    parameter int  POOL_W = POOL2_W,
    localparam int N      = POOL_H * POOL_W,
    localparam int ROW_W  = 2 * POOL_W,
    localparam int IDX_W  = $clog2(2 * POOL_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pool_valid,
    output logic             o_pool_ready,
    input  logic [0:N-1]     i_pool_in,
`ifdef UNPOOL_SWITCH_EN
    input  logic [0:2*N-1]   i_pool_sel,
`endif
    output logic             o_row_valid,
    input  logic             i_row_ready,
    output logic [0:ROW_W-1] o_row,
    output logic [IDX_W-1:0] o_row_idx,
    output logic             o_row_last
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never depends on ready, and the source holds data until it transfers.

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * POOL_H - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] nxt_cnt;
    logic [0:N-1]     map_q;
    logic [0:ROW_W-1] row_q;
    logic [0:ROW_W-1] exp_row;
    logic [0:POOL_W-1] src_row;
    logic             emitting;
    logic             last_row;
    logic             beat;
    logic             accept;

    assign emitting = (state == ST_EMIT);
    assign last_row = (row_cnt == LAST_IDX);
    assign beat     = emitting & i_row_ready;
    assign nxt_cnt  = row_cnt + IDX_W'(1);

    // Ready in IDLE, and on the final beat so the next frame follows with no bubble.
    assign o_pool_ready = (state == ST_IDLE) | (beat & last_row);
    assign accept       = i_pool_valid & o_pool_ready;

    // The expander always computes the row that will be registered on this edge.
    always_comb begin
        src_row = map_q[int'(nxt_cnt[IDX_W-1:1]) * POOL_W +: POOL_W];
        if (accept) begin
            src_row = i_pool_in[0 +: POOL_W];
        end
    end

`ifdef UNPOOL_SWITCH_EN
    logic [0:2*N-1]   sel_q;
    logic [0:ROW_W-1] src_sel;
    logic             src_parity;

    always_comb begin
        src_sel    = sel_q[int'(nxt_cnt[IDX_W-1:1]) * ROW_W +: ROW_W];
        src_parity = nxt_cnt[0];
        if (accept) begin
            src_sel    = i_pool_sel[0 +: ROW_W];
            src_parity = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
        end else if (accept) begin
            sel_q <= i_pool_sel;
        end
    end

    unpool_row_expand #(.POOL_W(POOL_W)) u_expand (
        .pool_row (src_row),
        .sel_row  (src_sel),
        .parity   (src_parity),
        .out_row  (exp_row)
    );
`else
    unpool_row_expand #(.POOL_W(POOL_W)) u_expand (
        .pool_row (src_row),
        .out_row  (exp_row)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            row_cnt <= '0;
            map_q   <= '0;
            row_q   <= '0;
        end else if (accept) begin
            state   <= ST_EMIT;
            row_cnt <= '0;
            map_q   <= i_pool_in;
            row_q   <= exp_row;
        end else if (beat) begin
            if (last_row) begin
                state   <= ST_IDLE;
                row_cnt <= '0;
                row_q   <= '0;
            end else begin
                row_cnt <= nxt_cnt;
                row_q   <= exp_row;
            end
        end
    end

    assign o_row_valid = emitting;
    assign o_row       = row_q;
    assign o_row_idx   = row_cnt;
    assign o_row_last  = emitting & last_row;

endmodule

// File: tb/tb_unpoolchan2.sv
// Randomized self-checking bench for unpoolchan2 against a frame-level reference model.
`timescale 1ns/1ps
module tb_unpoolchan2;

`ifdef UNPOOL_SWITCH_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pool_valid;
    logic        o_pool_ready;
    logic [15:0] i_pool_in;
    logic [31:0] sel_drv;
    logic        o_row_valid;
    logic        i_row_ready;
    logic [7:0]  o_row;
    logic [2:0]  o_row_idx;
    logic        o_row_last;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;
    bit          mon_en   = 1'b0;

    // Expected rows in emission order: {last, idx[2:0], row[7:0]}
    logic [11:0] exp_q[$];
    logic [11:0] e;
    logic        exp_ready;

    unpoolchan2 dut (
        .clk          (clk),
        .rst          (rst),
        .i_pool_valid (i_pool_valid),
        .o_pool_ready (o_pool_ready),
        .i_pool_in    (i_pool_in),
`ifdef UNPOOL_SWITCH_EN
        .i_pool_sel   (sel_drv),
`endif
        .o_row_valid  (o_row_valid),
        .i_row_ready  (i_row_ready),
        .o_row        (o_row),
        .o_row_idx    (o_row_idx),
        .o_row_last   (o_row_last)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cell (y/2,x/2) drives output pixel (y,x); map/sel are MSB-first.
    function automatic void push_frame(input logic [15:0] m, input logic [31:0] s);
        for (int y = 0; y < 8; y++) begin
            logic [7:0] r;
            r = '0;
            for (int x = 0; x < 8; x++) begin
                int   k;
                logic b;
                k = (y / 2) * 4 + x / 2;
                b = m[15 - k];
                if (SW_EN)
                    b = b && (s[31 - 2*k] == y[0]) && (s[30 - 2*k] == x[0]);
                r[7 - x] = b;
            end
            exp_q.push_back({(y == 7), 3'(y), r});
        end
    endfunction

    // Scoreboard: every cycle compare visible outputs to the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && i_row_ready);
            check_eq("pool_ready", {31'd0, o_pool_ready}, {31'd0, exp_ready});
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check_eq("row_valid", {31'd0, o_row_valid}, 32'd1);
                check_eq("row",       {24'd0, o_row},       {24'd0, e[7:0]});
                check_eq("row_idx",   {29'd0, o_row_idx},   {29'd0, e[10:8]});
                check_eq("row_last",  {31'd0, o_row_last},  {31'd0, e[11]});
                if (i_row_ready) void'(exp_q.pop_front());
            end else begin
                check_eq("row_valid_idle", {31'd0, o_row_valid}, 32'd0);
            end
            if (rst)
                exp_q.delete();
            else if (i_pool_valid && exp_ready)
                push_frame(i_pool_in, sel_drv);
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        i_row_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_row_ready = 1'b1;
                1:       i_row_ready = ~i_row_ready;
                default: i_row_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_map(input logic [15:0] m, input logic [31:0] s, input bit keep);
        bit hit;
        hit = 1'b0;
        i_pool_valid = 1'b1;
        i_pool_in    = m;
        sel_drv      = s;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            hit = o_pool_ready;
            @(posedge clk);
            #1;
        end
        if (!hit) check_eq("accept_timeout", {31'd0, o_pool_ready}, 32'd1);
        if (!keep) i_pool_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
        end
        if (!done) check_eq("idle_timeout", {31'd0, o_row_valid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_row(input logic [2:0] idx);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk);
            #1;
            found = o_row_valid && (o_row_idx == idx);
        end
        if (!found) check_eq("row_wait_timeout", {29'd0, o_row_idx}, {29'd0, idx});
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_eq({tag, "_pool_ready"}, {31'd0, o_pool_ready}, 32'd1);
        check_eq({tag, "_row_valid"},  {31'd0, o_row_valid},  32'd0);
        check_eq({tag, "_row"},        {24'd0, o_row},        32'd0);
        check_eq({tag, "_row_idx"},    {29'd0, o_row_idx},    32'd0);
        check_eq({tag, "_row_last"},   {31'd0, o_row_last},   32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        i_pool_valid = 1'b0;
        i_pool_in    = '0;
        sel_drv      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // single frame, corner cells
        send_map(16'h8001, 32'h0, 1'b0);
        wait_idle();

        // all-ones frame under alternating backpressure
        rdy_mode = 1;
        send_map(16'hFFFF, 32'h0, 1'b0);
        wait_idle();
        rdy_mode = 0;

        // back-to-back frames, second presented during the last beat
        send_map(16'hA5A5, 32'h0, 1'b1);
        send_map(16'h0F0F, 32'h0, 1'b0);
        wait_idle();

        // reset on the row-3 beat, then a clean frame
        send_map(16'h5AC3, 32'h0, 1'b0);
        wait_row(3'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        send_map(16'h3C3C, 32'h0, 1'b0);
        wait_idle();

        // valid pulsed mid-frame must be ignored
        send_map(16'h1234, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        i_pool_valid = 1'b1;
        i_pool_in    = 16'hFFFF;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        i_pool_valid = 1'b0;
        wait_idle();

        // reset coinciding with last beat and a new map: map is dropped
        send_map(16'h0FF0, 32'h0, 1'b0);
        wait_row(3'd7);
        i_pool_valid = 1'b1;
        i_pool_in    = 16'hFFFF;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        i_pool_valid = 1'b0;
        check_reset_outputs("rst_last");

`ifdef UNPOOL_SWITCH_EN
        // cell (3,3) with {dy,dx}={1,0}: only row 7 column 6
        send_map(16'h0001, 32'h0000_0002, 1'b0);
        wait_idle();
        send_map(16'hFFFF, 32'h1B1B_E4E4, 1'b0);
        wait_idle();
`endif

        // randomized frames, random backpressure and random back-to-back chaining
        rdy_mode = 2;
        for (int i = 0; i < 24; i++) begin
            bit chain;
            chain = 1'($urandom_range(0, 1));
            send_map(16'($urandom), $urandom, chain);
            if (!chain) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        i_pool_valid = 1'b0;
        wait_idle();
        rdy_mode = 0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
